// File: rtl/motor_drive_controller.sv
// motor_drive_controller: collision-driven reverse/pivot maneuver sequencer with dead-time-protected PWM drive
module motor_drive_controller #(
  parameter int unsigned DEAD_CYCLES = 5_000_000,
  parameter int unsigned REV_CYCLES  = 25_000_000,
  parameter int unsigned TURN_CYCLES = 20_000_000,
  parameter logic [7:0]  REV_DUTY    = 8'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       col_detect,
  input  logic [7:0] speed,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic [1:0] state_out
);
  typedef enum logic [1:0] {FWD = 2'd0, DEAD = 2'd1, REV = 2'd2, TURN = 2'd3} state_t;
  state_t st, st_d;
  logic [2:0] nx, nx_d;
  logic [25:0] cnt, cnt_d;
  logic [7:0] pc, pc_d, dq, dq_d, sel;
  logic done, enter;
  always_comb begin
    st_d = st;
    nx_d = nx;
    done = 1'b0;
    case (st)
      FWD: if (!col_detect) begin
        st_d = DEAD;
        nx_d = {1'b0, REV};
      end
      DEAD: begin
        done = cnt == 26'(DEAD_CYCLES - 1);
        if (done) st_d = state_t'(nx[1:0]);
      end
      REV: begin
        done = cnt == 26'(REV_CYCLES - 1);
        if (done) begin
          st_d = DEAD;
          nx_d = {1'b0, TURN};
        end
      end
      default: begin
        done = cnt == 26'(TURN_CYCLES - 1);
        if (done && col_detect) begin
          st_d = DEAD;
          nx_d = {1'b0, FWD};
        end
      end
    endcase
    // only DEAD can lead to a driving state, so entering one is also the sole moment directions may change
    enter = st_d != st && st_d != DEAD;
    cnt_d = (done || st_d != st || st == FWD) ? '0 : cnt + 26'd1;
    sel = st_d == FWD ? speed : REV_DUTY;
    pc_d = enter ? 8'd0 : pc + 8'd1;
    dq_d = (enter || pc == 8'hff) ? sel : dq;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= DEAD;
      nx <= {1'b0, FWD};
      cnt <= '0;
      pc <= '0;
      dq <= '0;
      pwm_l <= 1'b0;
      pwm_r <= 1'b0;
      dir_l <= 1'b1;
      dir_r <= 1'b1;
    end else begin
      st <= st_d;
      nx <= nx_d;
      cnt <= cnt_d;
      pc <= pc_d;
      dq <= dq_d;
      pwm_l <= st_d != DEAD && pc_d < dq_d;
      pwm_r <= st_d != DEAD && pc_d < dq_d;
      if (enter) begin
        dir_l <= st_d != REV;
        dir_r <= st_d == FWD;
      end
    end
  end
  assign state_out = st;
endmodule

// File: tb/tb_motor_drive_controller.sv
// tb_motor_drive_controller: vector table, corner sequences and random run against a phase-timeline reference model
module tb_motor_drive_controller;
  localparam int DC = 4, RC = 10, TC = 8;
  localparam logic [7:0] RD = 8'd64;
  logic clk = 0, rst = 1, col_detect = 1;
  logic [7:0] speed = 8'd128;
  logic pwm_l, pwm_r, dir_l, dir_r;
  logic [1:0] state_out;
  int checks = 0, failures = 0, hi = 0;
  int m_st, m_age, m_nx, m_pc, m_duty;
  bit m_pwm, m_dl, m_dr, p_pwm, p_dl, p_dr;
  typedef struct {bit col; logic [7:0] sp; int n; int st; bit pwm; bit dl; bit dr;} vec_t;
  vec_t tbl[16];

  always #5 clk = ~clk;

  motor_drive_controller #(.DEAD_CYCLES(DC), .REV_CYCLES(RC), .TURN_CYCLES(TC), .REV_DUTY(RD)) dut (
    .clk(clk), .rst(rst), .col_detect(col_detect), .speed(speed),
    .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r), .state_out(state_out)
  );

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st = 1; m_age = 0; m_nx = 0; m_pc = 0; m_duty = 0; m_pwm = 0; m_dl = 1; m_dr = 1;
  endtask

  task automatic mon_reset();
    p_pwm = 0; p_dl = 1; p_dr = 1;
  endtask

  // model tracks time-in-phase and applies the maneuver rules directly
  task automatic m_step();
    int ns;
    bit restart;
    if (rst) begin
      m_reset();
      return;
    end
    ns = m_st;
    restart = 0;
    if (m_st == 0 && !col_detect) begin ns = 1; m_nx = 2; end
    else if (m_st == 1 && m_age + 1 == DC) ns = m_nx;
    else if (m_st == 2 && m_age + 1 == RC) begin ns = 1; m_nx = 3; end
    else if (m_st == 3 && m_age + 1 == TC) begin
      if (col_detect) begin ns = 1; m_nx = 0; end
      else restart = 1;
    end
    if (ns != m_st && ns != 1) begin
      m_pc = 0;
      m_duty = ns == 0 ? int'(speed) : int'(RD);
      m_dl = ns != 2;
      m_dr = ns == 0;
    end else if (m_pc == 255) begin
      m_pc = 0;
      m_duty = ns == 0 ? int'(speed) : (ns == 1 ? 0 : int'(RD));
    end else m_pc++;
    m_age = (ns != m_st || restart) ? 0 : m_age + 1;
    m_st = ns;
    m_pwm = m_st != 1 && m_pc < m_duty;
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    chk("model_state", state_out, m_st);
    chk("model_pwm_l", pwm_l, m_pwm);
    chk("model_pwm_r", pwm_r, m_pwm);
    chk("model_dir_l", dir_l, m_dl);
    chk("model_dir_r", dir_r, m_dr);
    if (dir_l != p_dl || dir_r != p_dr) chk("dir_change_while_pwm", p_pwm, 0);
    p_pwm = pwm_l | pwm_r;
    p_dl = dir_l;
    p_dr = dir_r;
    hi += int'(pwm_l);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{1, 8'd128, 0,   1, 0, 1, 1},
      '{1, 8'd128, 3,   1, 0, 1, 1},
      '{1, 8'd128, 1,   0, 1, 1, 1},
      '{1, 8'd128, 127, 0, 1, 1, 1},
      '{1, 8'd128, 1,   0, 0, 1, 1},
      '{1, 8'd128, 128, 0, 1, 1, 1},
      '{0, 8'd128, 1,   1, 0, 1, 1},
      '{1, 8'd128, 3,   1, 0, 1, 1},
      '{1, 8'd128, 1,   2, 1, 0, 0},
      '{1, 8'd128, 9,   2, 1, 0, 0},
      '{1, 8'd128, 1,   1, 0, 0, 0},
      '{1, 8'd128, 4,   3, 1, 1, 0},
      '{0, 8'd128, 8,   3, 1, 1, 0},
      '{1, 8'd128, 7,   3, 1, 1, 0},
      '{1, 8'd128, 1,   1, 0, 1, 0},
      '{1, 8'd128, 4,   0, 1, 1, 1}
    };
    m_reset();
    mon_reset();
    repeat (3) tick();
    rst = 0;
    foreach (tbl[i]) begin
      col_detect = tbl[i].col;
      speed = tbl[i].sp;
      repeat (tbl[i].n) tick();
      chk($sformatf("tbl%0d_state", i), state_out, tbl[i].st);
      chk($sformatf("tbl%0d_pwm", i), pwm_l, tbl[i].pwm);
      chk($sformatf("tbl%0d_dir_l", i), dir_l, tbl[i].dl);
      chk($sformatf("tbl%0d_dir_r", i), dir_r, tbl[i].dr);
    end
    // duty changes mid-period only take effect at the next wrap
    speed = 8'd200;
    repeat (256) tick();
    repeat (50) tick();
    speed = 8'd10;
    repeat (149) tick();
    chk("keep_200_cnt199", pwm_l, 1);
    tick();
    chk("keep_200_cnt200", pwm_l, 0);
    repeat (56) tick();
    hi = 0;
    repeat (256) tick();
    chk("next_period_10", hi, 10);
    speed = 8'd0;
    repeat (256) tick();
    hi = 0;
    repeat (256) tick();
    chk("speed0_high", hi, 0);
    speed = 8'd255;
    repeat (256) tick();
    hi = 0;
    repeat (256) tick();
    chk("speed255_high", hi, 255);
    // asynchronous reset in the middle of REV with the PWM high
    col_detect = 0;
    tick();
    col_detect = 1;
    repeat (4) tick();
    chk("rev_state_pre", state_out, 2);
    chk("rev_pwm_pre", pwm_l, 1);
    #2 rst = 1;
    #1;
    chk("async_pwm_l", pwm_l, 0);
    chk("async_pwm_r", pwm_r, 0);
    chk("async_dir_l", dir_l, 1);
    chk("async_dir_r", dir_r, 1);
    chk("async_state", state_out, 1);
    m_reset();
    mon_reset();
    repeat (2) tick();
    rst = 0;
    repeat (3) tick();
    chk("post_rst_dead", state_out, 1);
    tick();
    chk("post_rst_fwd", state_out, 0);
    repeat (3000) begin
      col_detect = $urandom_range(0, 15) != 0;
      if ($urandom_range(0, 63) == 0) speed = 8'($urandom);
      rst = $urandom_range(0, 999) == 0;
      if (rst) begin
        #1;
        m_reset();
        mon_reset();
      end
      tick();
      rst = 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/motor_drive_controller.md
MOTOR_DRIVE_CONTROLLER -- requirements
Module: motor_drive_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEAD_CYCLES    5_000_000    both PWM outputs held low before any direction change (100 ms at 50 MHz)
  REV_CYCLES     25_000_000   reverse phase length
  TURN_CYCLES    20_000_000   pivot-turn phase length
  REV_DUTY       8'd128       duty used in REV and TURN
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk         in   1  system clock, 50 MHz
  rst         in   1  reset, asynchronous, active-high
  col_detect  in   1  from collision detector; 1 = drive permitted, 0 = stop; synchronous to clk, already debounced
  speed       in   8  forward duty request, 0 = stopped, 255 = 255/256 duty
  pwm_l       out  1  left motor enable PWM
  pwm_r       out  1  right motor enable PWM
  dir_l       out  1  left motor direction, 1 = forward
  dir_r       out  1  right motor direction, 1 = forward
  state_out   out  2  current state code, for LEDs
REQ-003 All outputs SHALL be registered on clk.

Function
REQ-004 State encodings SHALL be FWD=0, DEAD=1, REV=2, TURN=3; state_out SHALL equal the state register.
REQ-005 A single phase counter of at least 26 bits SHALL count clk cycles in DEAD, REV and TURN, and SHALL clear on every state change.
REQ-006 A 3-bit next register SHALL hold the state entered when DEAD completes.
REQ-007 FWD: dir_l=dir_r=1, duty=speed; col_detect=0 sampled on edge N SHALL move state to DEAD with next=REV on edge N.
REQ-008 DEAD: pwm_l=pwm_r=0 on every cycle; after exactly DEAD_CYCLES cycles in DEAD, state SHALL become next.
REQ-009 REV: dir_l=dir_r=0, duty=REV_DUTY; after REV_CYCLES cycles, state SHALL become DEAD with next=TURN.
REQ-010 TURN: dir_l=1, dir_r=0, duty=REV_DUTY; after TURN_CYCLES cycles: col_detect=1 -> DEAD with next=FWD; col_detect=0 -> stay in TURN and restart the counter.
REQ-011 col_detect SHALL be ignored in DEAD and REV, and in TURN before the phase ends; a maneuver, once started, SHALL always complete.
REQ-012 dir_l and dir_r SHALL change only on the edge that leaves DEAD, so no direction change ever coincides with a high PWM output.
REQ-013 An 8-bit pwm_cnt SHALL free-run, incrementing every clk and wrapping 255->0.
REQ-014 PWM output SHALL be 1 when pwm_cnt < duty_q and 0 otherwise; duty 0 SHALL give a constant 0, and duty 255 SHALL give 255 high cycles per 256.
REQ-015 duty_q SHALL load the state-selected duty only on the pwm_cnt 255->0 wrap, so a speed change mid-period takes effect at the next period.
REQ-016 pwm_l and pwm_r SHALL be 0 from the same edge on which state becomes DEAD, without waiting for the wrap.
REQ-017 On entry to FWD, REV or TURN, duty_q SHALL load immediately on that edge, and pwm_cnt SHALL clear to 0.

Reset
REQ-018 rst=1 SHALL immediately force: state=DEAD, next=FWD, counter=0, pwm_cnt=0, duty_q=0, pwm_l=pwm_r=0, dir_l=dir_r=1, state_out=1.
REQ-019 After rst is released, the block SHALL spend DEAD_CYCLES cycles in DEAD before entering FWD.
REQ-020 rst asserted mid-maneuver SHALL abandon the maneuver, with no recovery of the prior state.

Verification
Benches use DEAD=4, REV=10, TURN=8, REV_DUTY=64.
REQ-021 Release reset with col_detect=1 and speed=128 -> state_out=1 for 4 cycles, then 0; pwm_l high for 128 of every 256 cycles; dir=11.
REQ-022 Drop col_detect to 0 in FWD at edge N -> pwm=0 at N; sequence DEAD(4) -> REV(10, dir=00) -> DEAD(4) -> TURN(8, dir_l=1, dir_r=0) -> DEAD(4) -> FWD, with col_detect restored during REV.
REQ-023 Hold col_detect=0 through TURN -> TURN repeats in 8-cycle blocks; raise it -> exit at the next TURN boundary via DEAD.
REQ-024 Change speed 200 -> 10 at pwm_cnt=50 -> the current period keeps duty 200; the next period has 10 high cycles; speed=0 -> pwm constant 0; speed=255 -> one low cycle per period.
REQ-025 Assert rst during REV with pwm high -> pwm=0 and dir=11 immediately, without waiting for clk; on release -> 4-cycle DEAD then FWD.
REQ-026 Monitor all runs -> dir_l/dir_r never change in a cycle where pwm_l or pwm_r is 1.
